// File: rtl/tank_irrigation_ctrl_if.sv
// Signal bundle between the tank level sensors / operator inputs and the
// irrigation controller, plus the valve, alarm and level outputs.
interface tank_irrigation_ctrl_if;
  logic       i_H;
  logic       i_M;
  logic       i_L;
  logic       i_ct;
  logic       i_start;
  logic       i_clr_fault;
  logic       o_fill;
  logic       o_irr;
  logic       o_alarm;
  logic       o_err;
  logic [1:0] o_level;
  logic [2:0] o_state;

  modport slave (
    input  i_H, i_M, i_L, i_ct, i_start, i_clr_fault,
    output o_fill, o_irr, o_alarm, o_err, o_level, o_state
  );

  modport master (
    output i_H, i_M, i_L, i_ct, i_start, i_clr_fault,
    input  o_fill, o_irr, o_alarm, o_err, o_level, o_state
  );
endinterface

// File: rtl/tank_irrigation_ctrl.sv
// Tank fill / irrigation sequencer: synchronizes and debounces the level
// sensors, then runs a Moore FSM driving the inlet and irrigation valves.
module tank_irrigation_ctrl #(
  parameter int DEB_CYCLES   = 16,
  parameter int FILL_TIMEOUT = 1024,
  parameter int IRR_CYCLES   = 256
) (
  input logic                  clk,
  input logic                  rst_n,
  tank_irrigation_ctrl_if.slave bus
);

  localparam int TMR_MAX = (FILL_TIMEOUT > IRR_CYCLES) ? FILL_TIMEOUT : IRR_CYCLES;
  localparam int TW      = $clog2(TMR_MAX + 1);
  localparam int DW      = $clog2(DEB_CYCLES + 1);

  localparam logic [TW-1:0] TMR_ONE   = TW'(1);
  localparam logic [TW-1:0] TMR_SAT   = {TW{1'b1}};
  localparam logic [TW-1:0] FILL_LAST = TW'(FILL_TIMEOUT - 1);
  localparam logic [TW-1:0] IRR_LAST  = TW'(IRR_CYCLES - 1);
  localparam logic [DW-1:0] DEB_ONE   = DW'(1);
  localparam logic [DW-1:0] DEB_DONE  = DW'(DEB_CYCLES);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_FILL     = 3'd1,
    S_READY    = 3'd2,
    S_IRRIGATE = 3'd3,
    S_FAULT    = 3'd4
  } state_t;

  logic [3:0]    r_sync1;
  logic [3:0]    r_sync2;
  logic          r_startPrev;
  logic [2:0]    r_samp;
  logic [DW-1:0] r_debCnt;
  logic          r_lvOk;
  logic          r_err;
  logic [1:0]    r_level;
  logic          r_pend;
  logic [TW-1:0] r_timer;
  state_t        r_state;

  logic [2:0]    w_hml;
  logic          w_startRise;
  logic [DW-1:0] w_debCntNext;
  logic          w_accept;
  logic          w_vecValid;
  logic [1:0]    w_vecLevel;
  state_t        w_stateNext;
  logic [TW-1:0] w_timerNext;
  logic          w_pendNext;

  assign w_hml       = r_sync2[3:1];
  assign w_startRise = r_sync2[0] & ~r_startPrev;

  // The run length counts consecutive identical synchronized samples and
  // saturates at DEB_CYCLES, so a stable vector keeps being accepted.
  always_comb begin
    w_debCntNext = r_debCnt;
    if (w_hml != r_samp) begin
      w_debCntNext = DEB_ONE;
    end else if (r_debCnt != DEB_DONE) begin
      w_debCntNext = r_debCnt + DEB_ONE;
    end
  end

  assign w_accept = (w_debCntNext == DEB_DONE);

  always_comb begin
    w_vecValid = 1'b1;
    w_vecLevel = 2'd0;
    case (w_hml)
      3'b000:  w_vecLevel = 2'd0;
      3'b001:  w_vecLevel = 2'd1;
      3'b011:  w_vecLevel = 2'd2;
      3'b111:  w_vecLevel = 2'd3;
      default: w_vecValid = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1     <= 4'd0;
      r_sync2     <= 4'd0;
      r_startPrev <= 1'b0;
      r_samp      <= 3'd0;
      r_debCnt    <= '0;
      r_lvOk      <= 1'b0;
      r_err       <= 1'b0;
      r_level     <= 2'd0;
    end else begin
      r_sync1     <= {bus.i_H, bus.i_M, bus.i_L, bus.i_start};
      r_sync2     <= r_sync1;
      r_startPrev <= r_sync2[0];
      r_samp      <= w_hml;
      r_debCnt    <= w_debCntNext;
      if (w_accept) begin
        r_lvOk <= 1'b1;
        if (w_vecValid) begin
          r_level <= w_vecLevel;
          r_err   <= 1'b0;
        end else begin
          r_err   <= 1'b1;
        end
      end
    end
  end

  // ct and sensor errors override every per-state rule; FAULT is exempt from
  // the error override so that it can sit there until the sensors recover.
  always_comb begin
    w_stateNext = r_state;
    if (!bus.i_ct) begin
      w_stateNext = S_IDLE;
    end else if (r_err && (r_state != S_FAULT)) begin
      w_stateNext = S_FAULT;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (r_lvOk) begin
            w_stateNext = (r_level < 2'd2) ? S_FILL : S_READY;
          end
        end
        S_FILL: begin
          if (r_level == 2'd3) begin
            w_stateNext = S_READY;
          end else if (r_timer >= FILL_LAST) begin
            w_stateNext = S_FAULT;
          end
        end
        S_READY: begin
          if (r_level < 2'd2) begin
            w_stateNext = S_FILL;
          end else if (r_pend && (r_level != 2'd0)) begin
            w_stateNext = S_IRRIGATE;
          end
        end
        S_IRRIGATE: begin
          if (r_level == 2'd0) begin
            w_stateNext = S_FILL;
          end else if (r_timer >= IRR_LAST) begin
            w_stateNext = S_READY;
          end
        end
        S_FAULT: begin
          if (bus.i_clr_fault && !r_err) begin
            w_stateNext = S_IDLE;
          end
        end
        default: w_stateNext = S_IDLE;
      endcase
    end
  end

  // One timer serves both FILL and IRRIGATE; it restarts on any state change.
  always_comb begin
    w_timerNext = r_timer;
    if (!bus.i_ct || (w_stateNext != r_state)) begin
      w_timerNext = '0;
    end else if (r_timer != TMR_SAT) begin
      w_timerNext = r_timer + TMR_ONE;
    end
  end

  always_comb begin
    w_pendNext = r_pend;
    if (!bus.i_ct ||
        ((w_stateNext == S_IRRIGATE) && (r_state != S_IRRIGATE)) ||
        ((w_stateNext == S_FAULT) && (r_state != S_FAULT))) begin
      w_pendNext = 1'b0;
    end else if (w_startRise) begin
      w_pendNext = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_timer <= '0;
      r_pend  <= 1'b0;
    end else begin
      r_state <= w_stateNext;
      r_timer <= w_timerNext;
      r_pend  <= w_pendNext;
    end
  end

  assign bus.o_fill  = (r_state == S_FILL);
  assign bus.o_irr   = (r_state == S_IRRIGATE);
  assign bus.o_alarm = (r_state == S_FAULT);
  assign bus.o_err   = r_err;
  assign bus.o_level = r_level;
  assign bus.o_state = r_state;

endmodule

// File: tb/tb_tank_irrigation_ctrl.sv
// Directed and randomized bench for tank_irrigation_ctrl, compared each cycle
// against a pin-history reference model of the controller rules.
module tb_tank_irrigation_ctrl;

  localparam int DEB = 4;
  localparam int FT  = 50;
  localparam int IRR = 20;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  tank_irrigation_ctrl_if bus ();

  tank_irrigation_ctrl #(
    .DEB_CYCLES  (DEB),
    .FILL_TIMEOUT(FT),
    .IRR_CYCLES  (IRR)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model: pins seen at each edge since reset release (edge 1 is index 0).
  logic [2:0] pinHist[$];
  bit         startHist[$];
  int         mState;
  int         mElapsed;
  bit         mPend;
  bit         mErr;
  bit         mLvOk;
  int         mLevel;

  logic [2:0] curHml;
  bit         curStart;
  bit         curCt;
  bit         curClr;

  function automatic logic [2:0] pinAt(int k);
    if (k < 1 || k > pinHist.size()) return 3'b000;
    return pinHist[k-1];
  endfunction

  function automatic bit startAt(int k);
    if (k < 1 || k > startHist.size()) return 1'b0;
    return startHist[k-1];
  endfunction

  task automatic modelClear();
    pinHist.delete();
    startHist.delete();
    mState   = 0;
    mElapsed = 0;
    mPend    = 0;
    mErr     = 0;
    mLvOk    = 0;
    mLevel   = 0;
  endtask

  // A vector is accepted at edge n when the DEB most recent synchronized
  // samples (pins of edges n-2 .. n-1-DEB) agree; the synchronizer adds 2.
  task automatic modelEdge();
    int n;
    int nxt;
    bit same;
    bit rise;
    logic [2:0] v;
    pinHist.push_back(curHml);
    startHist.push_back(curStart);
    n = pinHist.size();
    same = (n >= DEB);
    for (int j = 1; j < DEB; j++) begin
      if (pinAt(n - 2 - j) != pinAt(n - 2)) same = 0;
    end
    rise = startAt(n - 2) && !startAt(n - 3);

    nxt = mState;
    if (!curCt) nxt = 0;
    else if (mErr && mState != 4) nxt = 4;
    else begin
      case (mState)
        0: if (mLvOk) nxt = (mLevel < 2) ? 1 : 2;
        1: if (mLevel == 3) nxt = 2; else if (mElapsed + 1 == FT) nxt = 4;
        2: if (mLevel < 2) nxt = 1; else if (mPend) nxt = 3;
        3: if (mLevel == 0) nxt = 1; else if (mElapsed + 1 == IRR) nxt = 2;
        4: if (curClr && !mErr) nxt = 0;
        default: nxt = 0;
      endcase
    end

    if (!curCt || (nxt == 3 && mState != 3) || (nxt == 4 && mState != 4)) mPend = 0;
    else if (rise) mPend = 1;
    mElapsed = (!curCt || nxt != mState) ? 0 : mElapsed + 1;

    if (same) begin
      v = pinAt(n - 2);
      mLvOk = 1;
      case (v)
        3'b000: begin mLevel = 0; mErr = 0; end
        3'b001: begin mLevel = 1; mErr = 0; end
        3'b011: begin mLevel = 2; mErr = 0; end
        3'b111: begin mLevel = 3; mErr = 0; end
        default: mErr = 1;
      endcase
    end
    mState = nxt;
  endtask

  task automatic checkOutput(string tag, logic [7:0] observed, logic [7:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
    end
  endtask

  task automatic checkModel();
    checkOutput("state", 8'(bus.o_state), 8'(mState));
    checkOutput("fill",  8'(bus.o_fill),  8'(mState == 1));
    checkOutput("irr",   8'(bus.o_irr),   8'(mState == 3));
    checkOutput("alarm", 8'(bus.o_alarm), 8'(mState == 4));
    checkOutput("err",   8'(bus.o_err),   8'(mErr));
    checkOutput("level", 8'(bus.o_level), 8'(mLevel));
  endtask

  task automatic applyStimulus(logic [2:0] hml, bit st, bit ct, bit clr, int cycles);
    curHml   = hml;
    curStart = st;
    curCt    = ct;
    curClr   = clr;
    bus.i_H         = hml[2];
    bus.i_M         = hml[1];
    bus.i_L         = hml[0];
    bus.i_start     = st;
    bus.i_ct        = ct;
    bus.i_clr_fault = clr;
    for (int c = 0; c < cycles; c++) begin
      @(posedge clk);
      modelEdge();
      #1;
      checkModel();
    end
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    #1;
    checkOutput("rst_state", 8'(bus.o_state), 8'd0);
    checkOutput("rst_irr",   8'(bus.o_irr),   8'd0);
    checkOutput("rst_fill",  8'(bus.o_fill),  8'd0);
    checkOutput("rst_level", 8'(bus.o_level), 8'd0);
    checkOutput("rst_err",   8'(bus.o_err),   8'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    modelClear();
  endtask

  task automatic pulseStart(logic [2:0] hml);
    applyStimulus(hml, 1, 1, 0, 1);
    applyStimulus(hml, 0, 1, 0, 2);
  endtask

  initial begin
    logic [2:0] validTab [4];
    logic [2:0] rh;
    validTab[0] = 3'b000;
    validTab[1] = 3'b001;
    validTab[2] = 3'b011;
    validTab[3] = 3'b111;

    bus.i_H = 0; bus.i_M = 0; bus.i_L = 1;
    bus.i_start = 0; bus.i_ct = 1; bus.i_clr_fault = 0;
    curHml = 3'b001; curStart = 0; curCt = 1; curClr = 0;
    modelClear();
    #2;
    doReset();

    $display("[TB] power-up fill");
    applyStimulus(3'b001, 0, 1, 0, 6);
    checkOutput("pwr_idle", 8'(bus.o_state), 8'd0);
    applyStimulus(3'b001, 0, 1, 0, 1);
    checkOutput("pwr_fill_state", 8'(bus.o_state), 8'd1);
    checkOutput("pwr_fill_valve", 8'(bus.o_fill), 8'd1);
    applyStimulus(3'b111, 0, 1, 0, 6);
    checkOutput("full_wait", 8'(bus.o_state), 8'd1);
    applyStimulus(3'b111, 0, 1, 0, 1);
    checkOutput("full_ready", 8'(bus.o_state), 8'd2);
    checkOutput("full_fill_off", 8'(bus.o_fill), 8'd0);

    $display("[TB] timed irrigation");
    pulseStart(3'b111);
    checkOutput("irr_pend_wait", 8'(bus.o_state), 8'd2);
    applyStimulus(3'b111, 0, 1, 0, 1);
    checkOutput("irr_enter", 8'(bus.o_state), 8'd3);
    checkOutput("irr_valve", 8'(bus.o_irr), 8'd1);
    applyStimulus(3'b111, 0, 1, 0, 19);
    checkOutput("irr_last", 8'(bus.o_state), 8'd3);
    applyStimulus(3'b111, 0, 1, 0, 1);
    checkOutput("irr_done", 8'(bus.o_state), 8'd2);
    applyStimulus(3'b111, 0, 1, 0, 5);
    checkOutput("irr_pend_clr", 8'(bus.o_state), 8'd2);

    $display("[TB] abort and refill");
    pulseStart(3'b111);
    applyStimulus(3'b111, 0, 1, 0, 1);
    checkOutput("abort_irr", 8'(bus.o_state), 8'd3);
    applyStimulus(3'b000, 0, 1, 0, 6);
    checkOutput("abort_wait", 8'(bus.o_state), 8'd3);
    applyStimulus(3'b000, 0, 1, 0, 1);
    checkOutput("abort_fill", 8'(bus.o_state), 8'd1);
    checkOutput("abort_irr_off", 8'(bus.o_irr), 8'd0);
    pulseStart(3'b000);
    applyStimulus(3'b000, 0, 1, 0, 2);
    applyStimulus(3'b111, 0, 1, 0, 7);
    checkOutput("refill_ready", 8'(bus.o_state), 8'd2);
    applyStimulus(3'b111, 0, 1, 0, 1);
    checkOutput("refill_served", 8'(bus.o_state), 8'd3);
    applyStimulus(3'b111, 0, 1, 0, 20);
    checkOutput("refill_irr_done", 8'(bus.o_state), 8'd2);

    $display("[TB] fill timeout");
    applyStimulus(3'b001, 0, 1, 0, 7);
    checkOutput("to_fill", 8'(bus.o_state), 8'd1);
    applyStimulus(3'b011, 0, 1, 0, 49);
    checkOutput("to_before", 8'(bus.o_state), 8'd1);
    applyStimulus(3'b011, 0, 1, 0, 1);
    checkOutput("to_fault", 8'(bus.o_state), 8'd4);
    checkOutput("to_alarm", 8'(bus.o_alarm), 8'd1);
    applyStimulus(3'b001, 0, 1, 0, 7);
    applyStimulus(3'b001, 0, 1, 1, 1);
    checkOutput("to_clr_idle", 8'(bus.o_state), 8'd0);
    applyStimulus(3'b001, 0, 1, 0, 1);
    checkOutput("to_refill", 8'(bus.o_state), 8'd1);
    applyStimulus(3'b111, 0, 1, 0, 7);

    $display("[TB] invalid sensors");
    applyStimulus(3'b101, 0, 1, 0, 6);
    checkOutput("inv_err", 8'(bus.o_err), 8'd1);
    checkOutput("inv_level_hold", 8'(bus.o_level), 8'd3);
    applyStimulus(3'b101, 0, 1, 0, 1);
    checkOutput("inv_fault", 8'(bus.o_state), 8'd4);
    applyStimulus(3'b101, 0, 1, 1, 3);
    checkOutput("inv_clr_ignored", 8'(bus.o_state), 8'd4);
    applyStimulus(3'b111, 0, 1, 0, 6);
    checkOutput("inv_err_clear", 8'(bus.o_err), 8'd0);
    applyStimulus(3'b111, 0, 1, 1, 1);
    checkOutput("inv_clr_idle", 8'(bus.o_state), 8'd0);
    applyStimulus(3'b111, 0, 1, 0, 1);
    checkOutput("inv_ready", 8'(bus.o_state), 8'd2);

    $display("[TB] debounce, ct and reset");
    for (int k = 0; k < 10; k++) begin
      applyStimulus(3'b011, 0, 1, 0, 2);
      applyStimulus(3'b111, 0, 1, 0, 2);
    end
    checkOutput("deb_level", 8'(bus.o_level), 8'd3);
    checkOutput("deb_state", 8'(bus.o_state), 8'd2);
    applyStimulus(3'b111, 0, 1, 0, 8);
    applyStimulus(3'b001, 0, 1, 0, 10);
    checkOutput("ct_fill", 8'(bus.o_state), 8'd1);
    applyStimulus(3'b001, 0, 0, 0, 1);
    checkOutput("ct_idle", 8'(bus.o_state), 8'd0);
    checkOutput("ct_fill_off", 8'(bus.o_fill), 8'd0);
    applyStimulus(3'b001, 0, 1, 0, 1);
    checkOutput("ct_resume", 8'(bus.o_state), 8'd1);
    applyStimulus(3'b111, 0, 1, 0, 7);
    pulseStart(3'b111);
    applyStimulus(3'b111, 0, 1, 0, 5);
    checkOutput("rst_mid_irr", 8'(bus.o_irr), 8'd1);
    doReset();
    applyStimulus(3'b111, 0, 1, 0, 6);
    checkOutput("rst_relearn", 8'(bus.o_state), 8'd0);
    checkOutput("rst_level3", 8'(bus.o_level), 8'd3);
    applyStimulus(3'b111, 0, 1, 0, 1);
    checkOutput("rst_ready", 8'(bus.o_state), 8'd2);

    $display("[TB] randomized run");
    rh = 3'b111;
    for (int k = 0; k < 1500; k++) begin
      if ($urandom_range(0, 5) == 0) begin
        if ($urandom_range(0, 9) < 7) rh = validTab[$urandom_range(0, 3)];
        else rh = 3'($urandom_range(0, 7));
      end
      applyStimulus(rh, $urandom_range(0, 9) == 0, $urandom_range(0, 49) != 0,
                    $urandom_range(0, 7) == 0, 1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
